// File: rtl/nibble_serial_subtractor.sv
// Nibble-serial subtractor: computes a - b - bin one 4-bit slice per cycle,
// least-significant nibble first, with the borrow held in a register between
// slices. Operands and result use valid/ready handshakes.
module nibble_serial_subtractor #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             zero,
    output logic             busy
);

    localparam int unsigned NIBBLES = WIDTH / 4;
    localparam int unsigned CntW    = $clog2(NIBBLES) + 1;

    if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_width_check
        $error("nibble_serial_subtractor: WIDTH must be a multiple of 4 and at least 4");
    end

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic              borrow_q, borrow_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]  res_q, res_d;
    // Published result is kept apart from the shifting work register so it
    // stays stable until the next result is complete.
    logic [WIDTH-1:0]  diff_q, diff_d;
    logic              bout_q, bout_d;
    logic              zero_q, zero_d;

    logic [3:0]        slice_d;
    logic              slice_bout;
    logic [WIDTH-1:0]  res_next;
    logic              last_slice;

    // 4-bit full-subtractor slice on the current low nibbles and borrow register.
    always_comb begin
        logic c;
        logic x;
        logic y;
        slice_d = '0;
        c       = borrow_q;
        for (int i = 0; i < 4; i++) begin
            x          = a_q[i];
            y          = b_q[i];
            slice_d[i] = x ^ y ^ c;
            c          = (~x & y) | (c & (~x | y));
        end
        slice_bout = c;
        res_next   = {slice_d, res_q[WIDTH-1:4]};
        last_slice = (cnt_q == CntW'(NIBBLES - 1));
    end

    // Next-state, datapath updates and handshake outputs.
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        borrow_d  = borrow_q;
        cnt_d     = cnt_q;
        res_d     = res_q;
        diff_d    = diff_q;
        bout_d    = bout_q;
        zero_d    = zero_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        unique case (state_q)
            StIdle: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    a_d      = a;
                    b_d      = b;
                    borrow_d = bin;
                    cnt_d    = '0;
                    state_d  = StRun;
                end
            end
            StRun: begin
                a_d      = a_q >> 4;
                b_d      = b_q >> 4;
                borrow_d = slice_bout;
                res_d    = res_next;
                cnt_d    = cnt_q + 1'b1;
                if (last_slice) begin
                    diff_d  = res_next;
                    bout_d  = slice_bout;
                    zero_d  = (res_next == '0);
                    state_d = StDone;
                end
            end
            StDone: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            a_q      <= '0;
            b_q      <= '0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
            res_q    <= '0;
            diff_q   <= '0;
            bout_q   <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            borrow_q <= borrow_d;
            cnt_q    <= cnt_d;
            res_q    <= res_d;
            diff_q   <= diff_d;
            bout_q   <= bout_d;
            zero_q   <= zero_d;
        end
    end

    assign diff = diff_q;
    assign bout = bout_q;
    assign zero = zero_q;

endmodule
